data_fifo: RTL and testbench

- Parametrised multi-bit synchronous FIFO.
- Next generation of the team's single-bit flag FIFO: configurable data width, non-power-of-two depth, simultaneous push/pop at full, fill-level and almost-full/almost-empty outputs, sticky overflow/underflow flags, synchronous flush.
- Used as the general buffer between puzzle-stage pipelines; drop-in for any stage needing more than one bit per entry.

---
 rtl/fifo_pkg.sv | 16 +
 rtl/fifo_ptr.sv | 25 ++
 rtl/data_fifo.sv | 122 ++++++++++++
 tb/tb_data_fifo.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared helpers and types for the FIFO family
package fifo_pkg;

  // clog2 that never returns 0, so a 1-entry range still gets a 1-bit field
  function automatic int clog2_min1(input int n);
    int r;
    r = $clog2(n);
    return (r < 1) ? 1 : r;
  endfunction

  typedef struct packed {
    logic overflow;
    logic underflow;
  } fifo_status_t;

endpackage

// File: rtl/fifo_ptr.sv
// rtl/fifo_ptr.sv - modulo-DEPTH wrap-around pointer with enable and sync clear
module fifo_ptr #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              inc,
  output logic [ADDR_W-1:0] ptr
);

  // Explicit wrap so non-power-of-two depths never index past the array
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (clr) begin
      ptr <= '0;
    end else if (inc) begin
      if (ptr == ADDR_W'(DEPTH - 1)) ptr <= '0;
      else                           ptr <= ptr + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/data_fifo.sv
// rtl/data_fifo.sv - parametrised multi-bit synchronous FIFO with level flags
module data_fifo
  import fifo_pkg::*;
#(
  parameter  int WIDTH      = 8,
  parameter  int DEPTH      = 4,
  parameter  int AFULL_LVL  = DEPTH - 1,
  parameter  int AEMPTY_LVL = 1,
  localparam int ADDR_W     = clog2_min1(DEPTH),
  localparam int COUNT_W    = clog2_min1(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               push,
  input  logic [WIDTH-1:0]   push_data,
  input  logic               pop,
  output logic [WIDTH-1:0]   pop_data,
  output logic               pop_valid,
  output logic               full,
  output logic               empty,
  output logic               almost_full,
  output logic               almost_empty,
  output logic [COUNT_W-1:0] count,
  output logic               overflow,
  output logic               underflow
);

  if (WIDTH < 1) begin : g_bad_width
    $error("data_fifo: WIDTH must be >= 1");
  end
  if (DEPTH < 2) begin : g_bad_depth
    $error("data_fifo: DEPTH must be >= 2");
  end
  if (AFULL_LVL < 1 || AFULL_LVL > DEPTH) begin : g_bad_afull
    $error("data_fifo: AFULL_LVL out of range 1..DEPTH");
  end
  if (AEMPTY_LVL < 0 || AEMPTY_LVL > DEPTH - 1) begin : g_bad_aempty
    $error("data_fifo: AEMPTY_LVL out of range 0..DEPTH-1");
  end

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              pop_acc;
  logic              push_acc;
  fifo_status_t      status;

  assign full         = (count == COUNT_W'(DEPTH));
  assign empty        = (count == '0);
  assign almost_full  = (count >= COUNT_W'(AFULL_LVL));
  assign almost_empty = (count <= COUNT_W'(AEMPTY_LVL));
  assign overflow     = status.overflow;
  assign underflow    = status.underflow;

  // A push into a full FIFO is taken only when a same-cycle pop frees the slot
  assign pop_acc  = pop && !empty;
  assign push_acc = push && (!full || pop_acc);

  fifo_ptr #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .inc   (push_acc),
    .ptr   (wr_ptr)
  );

  fifo_ptr #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .inc   (pop_acc),
    .ptr   (rd_ptr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (!flush && push_acc) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else if (push_acc && !pop_acc) begin
      count <= count + COUNT_W'(1);
    end else if (pop_acc && !push_acc) begin
      count <= count - COUNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pop_data  <= '0;
      pop_valid <= 1'b0;
    end else if (flush) begin
      pop_data  <= '0;
      pop_valid <= 1'b0;
    end else if (pop_acc) begin
      pop_data  <= mem[rd_ptr];
      pop_valid <= 1'b1;
    end else begin
      pop_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status <= '0;
    end else if (flush) begin
      status <= '0;
    end else begin
      if (push && !push_acc) status.overflow  <= 1'b1;
      if (pop && empty)      status.underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_data_fifo.sv
// tb/tb_data_fifo.sv - scoreboard bench for data_fifo at DEPTH=4 and DEPTH=5
module tb_data_fifo;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;

  logic       push4 = 1'b0, pop4 = 1'b0;
  logic [7:0] push_data4 = '0, pop_data4;
  logic       pop_valid4, full4, empty4, afull4, aempty4, ovf4, udf4;
  logic [2:0] count4;

  logic       push5 = 1'b0, pop5 = 1'b0;
  logic [7:0] push_data5 = '0, pop_data5;
  logic       pop_valid5, full5, empty5, afull5, aempty5, ovf5, udf5;
  logic [2:0] count5;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [7:0] q4[$];
  logic [7:0] q5[$];

  always #5 clk = ~clk;

  data_fifo #(.WIDTH(8), .DEPTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .push(push4), .push_data(push_data4), .pop(pop4),
    .pop_data(pop_data4), .pop_valid(pop_valid4),
    .full(full4), .empty(empty4), .almost_full(afull4), .almost_empty(aempty4),
    .count(count4), .overflow(ovf4), .underflow(udf4)
  );

  data_fifo #(.WIDTH(8), .DEPTH(5), .AFULL_LVL(4), .AEMPTY_LVL(1)) dut5 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .push(push5), .push_data(push_data5), .pop(pop5),
    .pop_data(pop_data5), .pop_valid(pop_valid5),
    .full(full5), .empty(empty5), .almost_full(afull5), .almost_empty(aempty5),
    .count(count5), .overflow(ovf5), .underflow(udf5)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (rst_n && pop_valid4) begin
      if (q4.size() == 0) begin
        total_cnt++;
        $display("FAIL sb4_unexpected: got pop_data %0h expected no pop_valid", pop_data4);
      end else begin
        check("sb4_data", 32'(pop_data4), 32'(q4.pop_front()));
      end
    end
    if (rst_n && pop_valid5) begin
      if (q5.size() == 0) begin
        total_cnt++;
        $display("FAIL sb5_unexpected: got pop_data %0h expected no pop_valid", pop_data5);
      end else begin
        check("sb5_data", 32'(pop_data5), 32'(q5.pop_front()));
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // One clock of stimulus on dut4; an accepted pop queues its expected data
  task automatic op4(input logic ph, input logic [7:0] pd, input logic pp,
                     input logic acc, input logic [7:0] pe);
    push4 = ph; push_data4 = pd; pop4 = pp;
    if (pp && acc) q4.push_back(pe);
    cycle();
    push4 = 1'b0; pop4 = 1'b0;
  endtask

  task automatic fill4();
    op4(1, 8'h11, 0, 0, 0);
    op4(1, 8'h22, 0, 0, 0);
    op4(1, 8'h33, 0, 0, 0);
    op4(1, 8'h44, 0, 0, 0);
  endtask

  task automatic drain4_11_44();
    op4(0, 0, 1, 1, 8'h11);
    op4(0, 0, 1, 1, 8'h22);
    op4(0, 0, 1, 1, 8'h33);
    op4(0, 0, 1, 1, 8'h44);
  endtask

  // 12 interleaved ops for DEPTH=5: kind 1=push, 2=pop (data is expected)
  int         kind5 [12] = '{1, 1, 1, 1, 2, 1, 1, 2, 2, 1, 2, 2};
  logic [7:0] dat5  [12] = '{8'hb1, 8'hb2, 8'hb3, 8'hb4, 8'hb1, 8'hb5,
                             8'hb6, 8'hb2, 8'hb3, 8'hb7, 8'hb4, 8'hb5};
  int         cnt5  [12] = '{1, 2, 3, 4, 3, 4, 5, 4, 3, 4, 3, 2};
  logic       af5   [12] = '{0, 0, 0, 1, 0, 1, 1, 1, 0, 1, 0, 0};
  logic       ae5   [12] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

  initial begin
    #3;
    check("rst_count", 32'(count4), 0);
    check("rst_empty", 32'(empty4), 1);
    check("rst_full", 32'(full4), 0);
    check("rst_aempty", 32'(aempty4), 1);
    check("rst_afull", 32'(afull4), 0);
    check("rst_pop_valid", 32'(pop_valid4), 0);
    check("rst_pop_data", 32'(pop_data4), 0);
    check("rst_flags", 32'({ovf4, udf4}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    fill4();
    check("fill_full", 32'(full4), 1);
    check("fill_count", 32'(count4), 4);
    check("fill_afull", 32'(afull4), 1);
    drain4_11_44();
    cycle();
    check("drain_empty", 32'(empty4), 1);
    check("drain_flags", 32'({ovf4, udf4}), 0);

    fill4();
    op4(1, 8'h55, 1, 1, 8'h11);
    check("fullsim_count", 32'(count4), 4);
    check("fullsim_ovf", 32'(ovf4), 0);
    op4(0, 0, 1, 1, 8'h22);
    op4(0, 0, 1, 1, 8'h33);
    op4(0, 0, 1, 1, 8'h44);
    op4(0, 0, 1, 1, 8'h55);
    check("fullsim_empty", 32'(empty4), 1);

    fill4();
    op4(1, 8'h66, 0, 0, 0);
    check("ovf_count", 32'(count4), 4);
    check("ovf_set", 32'(ovf4), 1);
    drain4_11_44();
    check("ovf_dropped_empty", 32'(empty4), 1);
    op4(0, 0, 1, 0, 0);
    check("udf_set", 32'(udf4), 1);
    check("udf_pop_valid", 32'(pop_valid4), 0);
    check("ovf_sticky", 32'(ovf4), 1);
    cycle();
    check("udf_sticky", 32'(udf4), 1);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    check("flush_flags", 32'({ovf4, udf4}), 0);
    check("flush_count", 32'(count4), 0);

    op4(1, 8'h77, 1, 0, 0);
    check("emptysim_udf", 32'(udf4), 1);
    check("emptysim_count", 32'(count4), 1);
    check("emptysim_pop_valid", 32'(pop_valid4), 0);
    op4(0, 0, 1, 1, 8'h77);
    check("emptysim_empty", 32'(empty4), 1);

    for (int i = 0; i < 12; i++) begin
      push5 = (kind5[i] == 1);
      pop5  = (kind5[i] == 2);
      push_data5 = dat5[i];
      if (kind5[i] == 2) q5.push_back(dat5[i]);
      cycle();
      push5 = 1'b0; pop5 = 1'b0;
      check($sformatf("d5_count_%0d", i), 32'(count5), 32'(cnt5[i]));
      check($sformatf("d5_afull_%0d", i), 32'(afull5), 32'(af5[i]));
      check($sformatf("d5_aempty_%0d", i), 32'(aempty5), 32'(ae5[i]));
    end
    q5.push_back(8'hb6);
    pop5 = 1'b1;
    cycle();
    q5.push_back(8'hb7);
    cycle();
    pop5 = 1'b0;
    check("d5_empty", 32'(empty5), 1);
    check("d5_flags", 32'({ovf5, udf5, full5}), 0);

    op4(1, 8'ha1, 0, 0, 0);
    op4(1, 8'ha2, 0, 0, 0);
    op4(1, 8'ha3, 0, 0, 0);
    op4(1, 8'ha4, 0, 0, 0);
    op4(0, 0, 1, 1, 8'ha1);
    check("arst_pre_count", 32'(count4), 3);
    check("arst_pre_valid", 32'(pop_valid4), 1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_count", 32'(count4), 0);
    check("arst_empty", 32'(empty4), 1);
    check("arst_pop_valid", 32'(pop_valid4), 0);
    check("arst_pop_data", 32'(pop_data4), 0);
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
    check("arst_still_empty", 32'(empty4), 1);

    check("sb4_drained", 32'(q4.size()), 0);
    check("sb5_drained", 32'(q5.size()), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
